// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI transaction arbiter: FSM states, master
// register encodings and a helper that builds the CONFIG byte.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        TXW,
        CMD,
        POLL,
        RD,
        DONE,
        GAP
    } state_t;

    // CONFIG register field offsets: {CLKDIV[3:0], slave[1:0], mode[1:0]}
    localparam int CFG_MODE_LSB  = 0;
    localparam int CFG_SLAVE_LSB = 2;
    localparam int CFG_DIV_LSB   = 4;

    localparam logic [7:0] CMD_START      = 8'h01;
    localparam int         STATE_BUSY_BIT = 0;

    function automatic logic [7:0] make_config(input logic [3:0] div,
                                               input logic [1:0] slave,
                                               input logic [1:0] mode);
        logic [7:0] cfg;
        cfg = '0;
        cfg[CFG_DIV_LSB   +: 4] = div;
        cfg[CFG_SLAVE_LSB +: 2] = slave;
        cfg[CFG_MODE_LSB  +: 2] = mode;
        return cfg;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or after ptr,
// wrapping around. Returns the winning index and whether any bit was set.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [1:0]   idx,
    output logic         valid
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [1:0]     off;
    logic [2:0]     sum;

    // Rotate so the pointer position lands at bit 0.
    assign dbl = {req, req};
    assign rot = N'(dbl >> ptr);

    // Lowest set bit of the rotated vector, mapped back to a requester index.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        valid = |req;
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = 2'(k);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= 3'(N)) ? 2'(sum - 3'(N)) : sum[1:0];
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one spi_master5 register port among up to four requesters. Each
// grant runs CONFIG write, TX write, start command, status polling and an RX
// read, then pulses ack to the granted requester.
module spi_txn_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int         NREQ     = 4,
    parameter logic [3:0] CLKDIV   = 4'd2,
    parameter logic [7:0] POLL_MAX = 8'd200
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   req_slave,
    input  logic [2*NREQ-1:0]   req_mode,
    input  logic [8*NREQ-1:0]   req_tx,
    output logic [NREQ-1:0]     ack,
    output logic                err,
    output logic [7:0]          rx_data,
    output logic                busy,
    output logic [1:0]          grant_id,
    output logic                WR0,
    output logic                WR1,
    output logic                WR2,
    output logic                WR3,
    output logic                DR0,
    output logic                DR1,
    output logic                DR2,
    output logic                DR3,
    output logic [7:0]          PWDATA,
    input  logic [7:0]          PRDATA
);

    state_t      state;
    logic [1:0]  rr_ptr;
    logic [1:0]  tx_pad;
    logic [7:0]  tx_q;
    logic [7:0]  poll_cnt;

    logic [1:0]  pick_idx;
    logic        pick_valid;
    logic [1:0]  sel_slave;
    logic [1:0]  sel_mode;
    logic [7:0]  sel_tx;
    logic [1:0]  ptr_next;
    logic [NREQ-1:0] ack_onehot;

    // RX register and the unused strobes are never driven by this block.
    assign WR2 = 1'b0;
    assign DR2 = 1'b0;
    assign DR3 = 1'b0;
    assign tx_pad = 2'b00;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Mux the winning requester's fields and derive the next pointer / ack mask.
    always_comb begin
        sel_slave  = '0;
        sel_mode   = '0;
        sel_tx     = '0;
        ack_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == 2'(i)) begin
                sel_slave = req_slave[2*i +: 2];
                sel_mode  = req_mode[2*i +: 2];
                sel_tx    = req_tx[8*i +: 8];
            end
            ack_onehot[i] = (grant_id == 2'(i));
        end
        ptr_next = (pick_idx == 2'(NREQ - 1)) ? 2'd0 : pick_idx + 2'd1;
    end

    // Transaction FSM; strobes and PWDATA are registered alongside the state
    // so each strobe is high exactly while its state is current.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            tx_q     <= '0;
            poll_cnt <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            ack      <= '0;
            err      <= 1'b0;
            rx_data  <= '0;
            WR0      <= 1'b0;
            WR1      <= 1'b0;
            WR3      <= 1'b0;
            DR0      <= 1'b0;
            DR1      <= 1'b0;
            PWDATA   <= '0;
        end else begin
            // NOTE: non-blocking assignments here; the defaults below are
            // overridden by the later assignment in the same case branch.
            WR0    <= 1'b0;
            WR1    <= 1'b0;
            WR3    <= 1'b0;
            DR0    <= 1'b0;
            DR1    <= 1'b0;
            PWDATA <= '0;
            ack    <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        tx_q     <= sel_tx;
                        rr_ptr   <= ptr_next;
                        busy     <= 1'b1;
                        WR0      <= 1'b1;
                        PWDATA   <= make_config(CLKDIV, sel_slave, sel_mode);
                        state    <= CFG;
                    end
                end
                CFG: begin
                    WR1    <= 1'b1;
                    PWDATA <= tx_q;
                    state  <= TXW;
                end
                TXW: begin
                    WR3      <= 1'b1;
                    PWDATA   <= CMD_START | {6'b0, tx_pad};
                    poll_cnt <= '0;
                    state    <= CMD;
                end
                CMD: begin
                    DR0   <= 1'b1;
                    state <= POLL;
                end
                POLL: begin
                    // The first sample is skipped: the master's busy flag
                    // rises one cycle after the start command.
                    if (poll_cnt != 8'd0 && !PRDATA[STATE_BUSY_BIT]) begin
                        DR1   <= 1'b1;
                        state <= RD;
                    end else if (poll_cnt == POLL_MAX - 8'd1) begin
                        err     <= 1'b1;
                        rx_data <= '0;
                        ack     <= ack_onehot;
                        state   <= DONE;
                    end else begin
                        DR0      <= 1'b1;
                        poll_cnt <= poll_cnt + 8'd1;
                    end
                end
                RD: begin
                    err     <= 1'b0;
                    rx_data <= PRDATA;
                    ack     <= ack_onehot;
                    state   <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= GAP;
                end
                GAP: begin
                    // Requests are ignored here so a requester that just got
                    // its ack and drops req is not granted again.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter with a small behavioural model of
// the spi_master5 status/RX registers.
module tb_spi_txn_arbiter;

    localparam int NREQ = 4;

    logic            PCLK = 1'b0;
    logic            PRESETn;
    logic [3:0]      req;
    logic [7:0]      req_slave;
    logic [7:0]      req_mode;
    logic [31:0]     req_tx;
    logic [3:0]      ack;
    logic            err;
    logic [7:0]      rx_data;
    logic            busy;
    logic [1:0]      grant_id;
    logic            WR0, WR1, WR2, WR3, DR0, DR1, DR2, DR3;
    logic [7:0]      PWDATA;
    logic [7:0]      PRDATA;

    spi_txn_arbiter #(.NREQ(NREQ), .CLKDIV(4'd2), .POLL_MAX(8'd200)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req       (req),
        .req_slave (req_slave),
        .req_mode  (req_mode),
        .req_tx    (req_tx),
        .ack       (ack),
        .err       (err),
        .rx_data   (rx_data),
        .busy      (busy),
        .grant_id  (grant_id),
        .WR0       (WR0),
        .WR1       (WR1),
        .WR2       (WR2),
        .WR3       (WR3),
        .DR0       (DR0),
        .DR1       (DR1),
        .DR2       (DR2),
        .DR3       (DR3),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA)
    );

    always #5 PCLK = ~PCLK;

    // Master model: busy for the first busy_polls status reads of a transfer,
    // optionally reading 0 on the very first poll; RX register returns rx_val.
    int         poll_idx = 0;
    int         busy_polls = 0;
    bit         first_zero = 1'b0;
    logic [7:0] rx_val = 8'h00;
    logic       model_busy;

    always @(posedge PCLK) begin
        if (WR3) poll_idx <= 0;
        else if (DR0) poll_idx <= poll_idx + 1;
    end

    always_comb begin
        model_busy = (poll_idx < busy_polls);
        if (first_zero && poll_idx == 0) model_busy = 1'b0;
    end

    assign PRDATA = DR1 ? rx_val : {7'b0, model_busy};

    // Bus rule monitor and ack counter.
    int strobe_viol = 0;
    int ack_total = 0;
    always @(negedge PCLK) begin
        if ($countones({WR0, WR1, WR2, WR3, DR0, DR1, DR2, DR3}) > 1) strobe_viol++;
        if (!(WR0 | WR1 | WR2 | WR3) && PWDATA != 8'h00) strobe_viol++;
        if (ack != 4'b0) ack_total++;
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic [1:0] id;
        logic [7:0] cfg;
        logic [7:0] tx;
        int         polls;
        bit         fz;
        logic [7:0] drv_rx;
        logic [7:0] exp_rx;
        bit         err;
        int         p;
        bit         b2b;
    } vec_t;

    vec_t tbl[9];

    // One full transaction; called just after a falling edge.
    task automatic run_vec(input vec_t v, input bit keep);
        int n;
        int k;
        busy_polls = v.polls;
        first_zero = v.fz;
        rx_val     = v.drv_rx;
        req        = v.req;
        n = 0;
        while (!WR0 && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        check("cfg_strobe", WR0, 1);
        if (v.b2b) check("b2b_gap", n, 2);
        check("cfg_pwdata", PWDATA, v.cfg);
        check("grant_id", grant_id, v.id);
        check("busy_cfg", busy, 1);
        @(negedge PCLK);
        check("txw", {WR1, PWDATA}, {1'b1, v.tx});
        @(negedge PCLK);
        check("cmd", {WR3, PWDATA}, {1'b1, 8'h01});
        k = 0;
        while (ack == 4'b0 && k < 400) begin
            @(negedge PCLK);
            k++;
        end
        // CFG is cycle 1, CMD cycle 3, ack lands at cycle 3+k.
        check("ack_cycle", 3 + k, v.err ? 4 + v.p : 5 + v.p);
        check("ack_vec", ack, 32'(1) << v.id);
        check("err", err, v.err);
        check("rx_data", rx_data, v.exp_rx);
        if (!keep) req = 4'b0;
        @(negedge PCLK);
        check("ack_pulse", {ack, busy}, 0);
    endtask

    initial begin
        int n;
        bit saw;
        vec_t v;

        // Requester fields: r0 s3/m0/A5, r1 s1/m2/3C, r2 s0/m3/5A, r3 s2/m1/FF
        req_slave = {2'd2, 2'd0, 2'd1, 2'd3};
        req_mode  = {2'd1, 2'd3, 2'd2, 2'd0};
        req_tx    = {8'hFF, 8'h5A, 8'h3C, 8'hA5};
        req       = 4'b0;

        //            req     id cfg    tx     polls fz drv    exp    err p    b2b
        tbl[0] = '{4'b0001, 0, 8'h2C, 8'hA5, 10,   0, 8'h5E, 8'h5E, 0, 11,  0};
        tbl[1] = '{4'b0010, 1, 8'h26, 8'h3C, 2,    1, 8'hC3, 8'hC3, 0, 3,   0};
        tbl[2] = '{4'b0100, 2, 8'h23, 8'h5A, 1000, 0, 8'h77, 8'h00, 1, 200, 0};
        tbl[3] = '{4'b1000, 3, 8'h29, 8'hFF, 1,    0, 8'h81, 8'h81, 0, 2,   0};
        tbl[4] = '{4'b1111, 0, 8'h2C, 8'hA5, 3,    0, 8'h11, 8'h11, 0, 4,   0};
        tbl[5] = '{4'b1111, 1, 8'h26, 8'h3C, 2,    0, 8'h22, 8'h22, 0, 3,   1};
        tbl[6] = '{4'b1111, 2, 8'h23, 8'h5A, 1,    0, 8'h33, 8'h33, 0, 2,   1};
        tbl[7] = '{4'b1111, 3, 8'h29, 8'hFF, 4,    0, 8'h44, 8'h44, 0, 5,   1};
        tbl[8] = '{4'b1111, 0, 8'h2C, 8'hA5, 1,    0, 8'h55, 8'h55, 0, 2,   1};

        PRESETn = 1'b1;
        #1 PRESETn = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("reset_outputs",
              {ack, err, rx_data, busy, grant_id, WR0, WR1, WR2, WR3, DR0, DR1, DR2, DR3, PWDATA}, 0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        for (int i = 0; i < 9; i++) begin
            run_vec(tbl[i], (i < 8) ? tbl[i + 1].b2b : 1'b0);
        end

        // Requester 1 drops req right after grant and changes its fields.
        busy_polls = 1;
        first_zero = 1'b0;
        rx_val     = 8'h6D;
        req        = 4'b0010;
        n = 0;
        while (!WR0 && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        check("drop_grant", {WR0, grant_id}, {1'b1, 2'd1});
        req = 4'b0;
        req_tx[15:8] = 8'h00;
        req_slave[3:2] = 2'd0;
        @(negedge PCLK);
        check("drop_tx_latched", {WR1, PWDATA}, {1'b1, 8'h3C});
        n = 0;
        while (ack == 4'b0 && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        check("drop_ack", {ack, err, rx_data}, {4'b0010, 1'b0, 8'h6D});
        @(negedge PCLK);
        req = 4'b0010;          // raised only during GAP
        @(negedge PCLK);
        req = 4'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge PCLK);
            if (WR0 || busy) saw = 1'b1;
        end
        check("gap_no_regrant", saw, 0);
        req_tx[15:8] = 8'h3C;
        req_slave[3:2] = 2'd1;

        // Reset during POLL abandons the transaction.
        busy_polls = 1000;
        req = 4'b0100;
        n = 0;
        while (!DR0 && n < 60) begin
            @(negedge PCLK);
            n++;
        end
        check("reach_poll", DR0, 1);
        @(negedge PCLK);
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        check("midreset_outputs",
              {ack, err, rx_data, busy, grant_id, WR0, WR1, WR2, WR3, DR0, DR1, DR2, DR3, PWDATA}, 0);
        req = 4'b0;
        saw = 1'b0;
        repeat (4) begin
            @(negedge PCLK);
            if (ack != 4'b0) saw = 1'b1;
        end
        check("midreset_no_ack", saw, 0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Pointer is back at 0, so requester 1 wins over 3.
        v = '{4'b1010, 1, 8'h26, 8'h3C, 2, 0, 8'h9C, 8'h9C, 0, 3, 0};
        run_vec(v, 1'b0);

        check("ack_total", ack_total, 11);
        check("strobe_rules", strobe_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Shares the single `spi_master5` register port among up to four on-chip requesters. Each granted requester gets one complete single-byte SPI transaction: slave select, mode, TX byte in; RX byte out. The block drives the master's WR0–WR3 and DR0–DR3 strobes and PWDATA, and reads PRDATA. Grants are round-robin, and the block polls the master status until the transfer ends or times out.

## Interface
- `NREQ`, 4: number of requesters (fixed 1–4).
- `CLKDIV`, 4'd2: SCK divider written into CONFIG[7:4].
- `POLL_MAX`, 8'd200: poll cycles before timeout.
- `PCLK` in 1: clock.
- `PRESETn` in 1: asynchronous, active-low reset.
- `req` in NREQ: per-requester request, held until `ack`.
- `req_slave` in 2*NREQ: slave select 0–3 per requester.
- `req_mode` in 2*NREQ: SPI mode per requester.
- `req_tx` in 8*NREQ: TX byte per requester.
- `ack` out NREQ: one-cycle completion pulse to the granted requester.
- `err` out 1: valid with `ack`; 1 means timeout.
- `rx_data` out 8: RX byte, valid with `ack`, held until the next `ack`.
- `busy` out 1: high from grant through DONE.
- `grant_id` out 2: index of the current or last grant.
- `WR0`, `WR1`, `WR2`, `WR3` out 1 each: master write strobes (CONFIG, TX, RX, CMD). `WR2` is tied to 0.
- `DR0`, `DR1`, `DR2`, `DR3` out 1 each: master read strobes (STATE, RX). `DR2` and `DR3` are tied to 0.
- `PWDATA` out 8: write data to the master.
- `PRDATA` in 8: read data from the master, valid in the same cycle as its DR strobe.

## Operation
- Register encodings:
  - CONFIG = {CLKDIV, slave[1:0], mode[1:0]}.
  - CMD start = 8'h01.
  - STATE bit0 = master busy.
- FSM states: IDLE, CFG, TXW, CMD, POLL, RD, DONE, GAP.
- IDLE: if `req` is non-zero, grant the first set bit at or after `rr_ptr` (wrapping). Latch the granted index and its slave, mode and TX fields. Set `rr_ptr` = granted+1 mod NREQ. Go to CFG.
- CFG: WR0=1, PWDATA=CONFIG.
- TXW: WR1=1, PWDATA=latched TX byte.
- CMD: WR3=1, PWDATA=8'h01. Clear the poll counter.
- POLL:
  - DR0=1 in every POLL cycle.
  - The first POLL cycle's sample is ignored, because the master's busy flag needs one cycle to rise.
  - From the second cycle on, PRDATA[0]=0 moves to RD.
  - If the counter reaches POLL_MAX, set the err flag and go to DONE; `rx_data` becomes 8'h00.
- RD: DR1=1, capture PRDATA into `rx_data`.
- DONE: `ack[grant_id]`=1 for one cycle; `err` is driven.
- GAP: one idle cycle in which `req` is ignored, so a requester that drops `req` after `ack` is not re-granted. Then go to IDLE.
- Only one strobe is ever high in a given cycle. Strobes and PWDATA are registered outputs. PWDATA is 0 whenever no WR strobe is high.
- Requester fields are latched at grant. Later changes to `req_*`, or `req` falling, do not affect the transaction; `ack` is still issued.

## Timing
- Reset (async) values: all strobes 0, PWDATA 0, `ack` 0, `err` 0, `rx_data` 0, `busy` 0, `grant_id` 0, `rr_ptr` 0, state IDLE.
- Reset mid-transaction: the transaction is abandoned and no `ack` is issued.
- Request to ack: with the grant edge as cycle 0, CFG=1, TXW=2, CMD=3, POLL=4..3+P, RD=4+P, DONE (ack)=5+P.
  - P is the number of POLL cycles and is at least 2.
  - Timeout: ack at cycle 4+POLL_MAX, with `err`=1.
- Back-to-back service: the next grant occurs at the earliest in cycle 7+P (after DONE and GAP).
- Simultaneous requests: pure round-robin; no requester waits more than NREQ-1 transactions.

## Structure
- Package `spi_ctrl_pkg` holds:
  - the FSM state enum;
  - CONFIG field offsets;
  - `CMD_START`=8'h01;
  - `STATE_BUSY_BIT`=0.
- One sub-module, `rr_arbiter`: a combinational pick of the first set bit from a pointer, returning the index and a valid flag.

## Test plan
- Single request: `req[0]`, slave 3, mode 0, tx 8'hA5; master stays busy for 10 polls.
  - Required: WR0 with PWDATA 8'h2C, then WR1 with 8'hA5, then WR3 with 8'h01.
  - Required: `ack[0]` at cycle 5+P, with `rx_data` = PRDATA sampled under DR1 and `err`=0.
- All four `req` high together: grants in order 0,1,2,3, then 0 again if `req[0]` is still held. Each `ack` is a single cycle.
- Timeout: master busy stuck at 1. Required: `ack` at cycle 4+POLL_MAX, `err`=1, `rx_data`=8'h00, and the next grant proceeds normally.
- First-cycle busy ignored: PRDATA[0]=0 on the first poll and 1 on the second. Required: no early RD.
- Requester drops `req` after grant: `ack` is still issued and the requester is not re-granted during GAP.
- PRESETn asserted during POLL: all outputs go to their reset values immediately, no `ack` is issued, and a fresh request after release completes normally.
